// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: matches the last PAT_W valid bits against a run-time loadable pattern.
// Latency: detected is registered and high in the cycle after the edge that samples the final pattern bit.
// Backpressure: none; one bit accepted per clock whenever seq_valid is high.
// Optional saturating match counter is built when SEQ_PATTERN_DETECTOR_COUNT_EN is defined.
module seq_pattern_detector #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b1010,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seq,
    input  logic             seq_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             detected,
    output logic [CNT_W-1:0] match_count
);

    localparam int               FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill_next;
    logic              match;

    // Next history/fill for the bit on the wire, and whether it completes a match.
    // The fill gate keeps the cleared history from matching an all-zero pattern.
    always_comb begin
        hist_next = {hist[PAT_W-2:0], seq};
        fill_next = (fill == FULL) ? FULL : fill + FILL_W'(1);
        match     = seq_valid && !pat_load && (hist_next == pattern) && (fill_next == FULL);
    end

    // Pattern, history, fill and the registered match pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern  <= PAT_DEFAULT;
            hist     <= '0;
            fill     <= '0;
            detected <= 1'b0;
        end else if (pat_load) begin
            pattern  <= pat_in;
            hist     <= '0;
            fill     <= '0;
            detected <= 1'b0;
        end else if (seq_valid) begin
            hist     <= hist_next;
            // Non-overlapping mode restarts the fill so the next match needs fresh bits.
            fill     <= (match && !overlap) ? '0 : fill_next;
            detected <= match;
        end else begin
            detected <= 1'b0;
        end
    end

`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    // Saturating match counter; a clear wins over a simultaneous match.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (match && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_count = cnt;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector with PAT_W=4, PAT_DEFAULT=4'b1010, CNT_W=2.
// Directed scenarios plus a randomized run compared against a bit-history reference model.
module tb_seq_pattern_detector;

    localparam int         PAT_W = 4;
    localparam logic [3:0] PDEF  = 4'b1010;
    localparam int         CW    = 2;
    localparam int         CMAX  = 3;
`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, seq, seq_valid, overlap, pat_load, cnt_clr;
    logic [3:0]    pat_in;
    logic          detected;
    logic [CW-1:0] match_count;

    int checks = 0;
    int errors = 0;

    // Reference model: pattern, recent valid bits, bits seen since the last restart, outputs.
    logic [3:0] m_pat;
    bit         m_bits[$];
    int         m_fresh;
    logic       m_det;
    int         m_cnt;

    seq_pattern_detector #(.PAT_W(PAT_W), .PAT_DEFAULT(PDEF), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .seq(seq), .seq_valid(seq_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .detected(detected), .match_count(match_count)
    );

    always #5 clk = ~clk;

    // Apply the rules to the inputs sampled at this edge.
    task automatic model_edge();
        logic [3:0] last;
        bit         m;
        m = 1'b0;
        if (reset) begin
            m_pat = PDEF; m_bits.delete(); m_fresh = 0; m_det = 1'b0; m_cnt = 0;
        end else begin
            if (pat_load) begin
                m_pat = pat_in; m_bits.delete(); m_fresh = 0; m_det = 1'b0;
            end else if (seq_valid) begin
                m_bits.push_back(seq);
                if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                m_fresh++;
                last = '0;
                if (m_fresh >= PAT_W)
                    for (int i = 0; i < PAT_W; i++) last = {last[2:0], m_bits[m_bits.size()-PAT_W+i]};
                m = (m_fresh >= PAT_W) && (last == m_pat);
                m_det = m;
                if (m && !overlap) m_fresh = 0;
            end else begin
                m_det = 1'b0;
            end
            if (CEN) begin
                if (cnt_clr) m_cnt = 0;
                else if (m && m_cnt < CMAX) m_cnt++;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, then settle away from the edge.
    task automatic step(input logic s, input logic v, input logic o, input logic l,
                        input logic [3:0] p, input logic c, input logic r);
        seq = s; seq_valid = v; overlap = o; pat_load = l; pat_in = p; cnt_clr = c; reset = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 4'h0, 0, 1);
        step(1, 1, 1, 0, 4'h0, 0, 1);
        checks++;
        if (detected !== 1'b0) begin errors++; $display("FAIL reset_det got %b want 0", detected); end
        checks++;
        if (match_count !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", match_count); end
    endtask

    task automatic test_overlap();
        logic [5:0] st = 6'b101010;
        logic [5:0] got = '0;
        step(0, 0, 1, 0, 4'h0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(st[5-i], 1, 1, 0, 4'h0, 0, 0);
            got[i] = detected;
            checks++;
            if (detected !== m_det) begin errors++; $display("FAIL overlap_det bit %0d got %b want %b", i+1, detected, m_det); end
        end
        checks++;
        if (got !== 6'b101000) begin errors++; $display("FAIL overlap_pulses got %b want 101000", got); end
        checks++;
        if (match_count !== CW'(CEN ? 2 : 0)) begin errors++; $display("FAIL overlap_cnt got %0d want %0d", match_count, CEN ? 2 : 0); end
    endtask

    task automatic test_nonoverlap();
        logic [7:0] st = 8'b10101010;
        logic [7:0] got = '0;
        step(0, 0, 0, 0, 4'h0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(st[7-i], 1, 0, 0, 4'h0, 0, 0);
            got[i] = detected;
            checks++;
            if (detected !== m_det) begin errors++; $display("FAIL nonoverlap_det bit %0d got %b want %b", i+1, detected, m_det); end
        end
        checks++;
        if (got !== 8'b10001000) begin errors++; $display("FAIL nonoverlap_pulses got %b want 10001000", got); end
    endtask

    task automatic test_valid_gaps();
        logic [6:0] sv = 7'b1100011;   // seq_valid per step, first step in MSB
        logic [6:0] sb = 7'b1000010;   // seq per step
        logic [6:0] got = '0;
        step(0, 0, 1, 0, 4'h0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            step(sb[6-i], sv[6-i], 1, 0, 4'h0, 0, 0);
            got[i] = detected;
        end
        checks++;
        if (got !== 7'b1000000) begin errors++; $display("FAIL gaps_pulses got %b want 1000000", got); end
    endtask

    task automatic test_runtime_load();
        logic [3:0] a = 4'b0011;
        logic [3:0] b = 4'b1010;
        logic [3:0] ga = '0;
        logic [3:0] gb = '0;
        step(0, 0, 1, 0, 4'h0, 0, 1);
        for (int i = 0; i < 4; i++) step(b[3-i], 1, 1, 0, 4'h0, 0, 0);
        step(1, 1, 1, 0, 4'h0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 0, 0);
        step(1, 1, 1, 1, 4'b0011, 0, 0);
        checks++;
        if (match_count !== CW'(CEN ? 1 : 0)) begin errors++; $display("FAIL load_keep_cnt got %0d want %0d", match_count, CEN ? 1 : 0); end
        checks++;
        if (detected !== 1'b0) begin errors++; $display("FAIL load_det got %b want 0", detected); end
        for (int i = 0; i < 4; i++) begin step(a[3-i], 1, 1, 0, 4'h0, 0, 0); ga[i] = detected; end
        for (int i = 0; i < 4; i++) begin step(b[3-i], 1, 1, 0, 4'h0, 0, 0); gb[i] = detected; end
        checks++;
        if (ga !== 4'b1000) begin errors++; $display("FAIL load_new_pat got %b want 1000", ga); end
        checks++;
        if (gb !== 4'b0000) begin errors++; $display("FAIL load_old_pat got %b want 0000", gb); end
        checks++;
        if (match_count !== CW'(CEN ? 2 : 0)) begin errors++; $display("FAIL load_cnt got %0d want %0d", match_count, CEN ? 2 : 0); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] b = 4'b1010;
        logic [3:0] got = '0;
        step(0, 0, 1, 0, 4'h0, 0, 1);
        step(1, 1, 1, 0, 4'h0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 0, 0);
        step(1, 1, 1, 0, 4'h0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 0, 1);
        checks++;
        if ({detected, match_count} !== '0) begin errors++; $display("FAIL rstmid_outs got det %b cnt %0d want 0 0", detected, match_count); end
        step(0, 1, 1, 0, 4'h0, 0, 0);
        checks++;
        if (detected !== 1'b0) begin errors++; $display("FAIL rstmid_nopulse got %b want 0", detected); end
        for (int i = 0; i < 4; i++) begin step(b[3-i], 1, 1, 0, 4'h0, 0, 0); got[i] = detected; end
        checks++;
        if (got !== 4'b1000) begin errors++; $display("FAIL rstmid_after got %b want 1000", got); end
    endtask

    task automatic test_counter_sat();
        logic [11:0] st = 12'b101010101010;
        step(0, 0, 1, 0, 4'h0, 0, 1);
        for (int i = 0; i < 12; i++) step(st[11-i], 1, 1, 0, 4'h0, 0, 0);
        checks++;
        if (match_count !== CW'(CEN ? 3 : 0)) begin errors++; $display("FAIL cnt_sat got %0d want %0d", match_count, CEN ? 3 : 0); end
        step(1, 1, 1, 0, 4'h0, 0, 0);
        step(0, 1, 1, 0, 4'h0, 1, 0);
        checks++;
        if (detected !== 1'b1) begin errors++; $display("FAIL cnt_clr_det got %b want 1", detected); end
        checks++;
        if (match_count !== '0) begin errors++; $display("FAIL cnt_clr_val got %0d want 0", match_count); end
    endtask

    task automatic test_random();
        logic       r, l, c, v, o;
        logic [3:0] p;
        step(0, 0, 0, 0, 4'h0, 0, 1);
        o = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(63) == 0);
            l = ($urandom_range(31) == 0);
            c = ($urandom_range(15) == 0);
            v = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) o = ~o;
            p = 4'($urandom);
            step(1'($urandom), v, o, l, p, c, r);
            checks++;
            if (detected !== m_det || match_count !== CW'(m_cnt)) begin
                errors++;
                $display("FAIL random cycle %0d got det %b cnt %0d want det %b cnt %0d",
                         i, detected, match_count, m_det, m_cnt);
            end
        end
    endtask

    initial begin
        m_pat = PDEF; m_fresh = 0; m_det = 1'b0; m_cnt = 0;
        reset = 1'b1; seq = 1'b0; seq_valid = 1'b0; overlap = 1'b0;
        pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_valid_gaps();
        test_runtime_load();
        test_reset_mid();
        test_counter_sat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector, the next generation of the fixed-sequence detector. It samples one bit per qualified clock and matches the last `PAT_W` bits against a pattern that software can change at run time. It supports overlapping and non-overlapping matches and emits a one-cycle `detected` pulse. An optional saturating match counter can be compiled in. It sits directly on a serial bit stream, such as a line decoder or frame-sync search.

## Interface
- `PAT_W`, 4: pattern length in bits; legal range 2..32.
- `PAT_DEFAULT`, 4'b1010: pattern value after reset; `PAT_W` bits.
- `CNT_W`, 8: match counter width; only used when the counter is compiled in.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `seq` input 1: serial data bit.
- `seq_valid` input 1: qualifies `seq`; a bit is consumed only when this is 1.
- `overlap` input 1: 1 = overlapping matches, 0 = non-overlapping; sampled every cycle.
- `pat_load` input 1: strobe that loads `pat_in` into the pattern register.
- `pat_in` input `PAT_W`: new pattern; MSB is the earliest bit of the sequence.
- `cnt_clr` input 1: clears the match counter.
- `detected` output 1: registered one-cycle match pulse.
- `match_count` output `CNT_W`: saturating match count; tied to 0 when the counter is compiled out.

## Operation
- State:
  - `pattern` (`PAT_W`).
  - `hist` shift register (`PAT_W`); the newest bit is the LSB.
  - `fill` counter, 0..`PAT_W`, saturating at `PAT_W`.
  - `detected` register.
  - `match_count` register.
- Reset (`reset`=1 at the edge):
  - `pattern`=`PAT_DEFAULT`, `hist`=0, `fill`=0, `detected`=0, `match_count`=0.
  - Reset overrides every other input.
- Pattern load (`pat_load`=1, `reset`=0):
  - `pattern`=`pat_in`, `hist`=0, `fill`=0, `detected`=0.
  - `seq_valid` is ignored that cycle.
  - `match_count` is unaffected.
- Bit consume (`seq_valid`=1, no load):
  - `hist_next`={`hist`[`PAT_W`-2:0], `seq`}.
  - `fill_next`=min(`fill`+1, `PAT_W`).
  - Match condition: `hist_next`==`pattern` AND `fill_next`==`PAT_W`.
  - On a match, `detected`<=1.
  - On a match with `overlap`=0: `fill`<=0, so the next match needs `PAT_W` fresh bits. `hist` still shifts.
  - On a match with `overlap`=1: `fill` stays at `PAT_W`.
- Idle (`seq_valid`=0): `hist` and `fill` hold; `detected`<=0.
- `detected` is high for exactly one cycle per match. Back-to-back matches on consecutive valid bits give consecutive high cycles.
- Counter: on each match `match_count` increments, saturating at 2^`CNT_W`-1 with no wrap.
- `cnt_clr`=1 sets `match_count` to 0. This takes priority over a simultaneous match, so the result is 0.
- The `fill` gate means no false match on an all-zero `hist` after reset or load.

## Timing
- Latency: `detected` is asserted in the cycle after the edge that samples the final pattern bit (1-cycle registered).
- `match_count` updates on the same edge that sets `detected`.
- A pattern load takes effect on the next edge. Bits presented in the load cycle are dropped.
- A change of `overlap` affects only matches evaluated on or after the edge where it is sampled.
- Reset mid-stream: `detected` is 0 in the following cycle. A partial match is discarded and needs `PAT_W` new valid bits.
- Throughput: one bit per clock. There is no backpressure.

## Configuration
- Macro: `SEQ_PATTERN_DETECTOR_COUNT_EN`.
- Defined:
  - The `match_count` register, saturation logic and `cnt_clr` handling are built.
- Undefined:
  - `match_count` is driven constant 0.
  - `cnt_clr` is ignored.
  - The port list is unchanged.
- Detection behaviour is identical in both builds.

## Test plan
All scenarios use `PAT_W`=4 and `PAT_DEFAULT`=4'b1010, with `seq_valid`=1 unless stated.
1. Overlap: `overlap`=1, stream 1,0,1,0,1,0.
   - `detected` is high after the 4th and 6th bits.
   - `match_count`=2.
2. Non-overlap: `overlap`=0, same stream.
   - `detected` is high after the 4th bit only.
   - Continuing with 1,0 gives a second pulse after bit 8.
3. Valid gaps: stream 1,0 then `seq_valid`=0 for 3 cycles, then 1,0.
   - Single `detected` pulse after the final bit.
   - No pulse during the gap.
4. Runtime load: load `pat_in`=4'b0011 after bits 1,0.
   - Stream 0,0,1,1 then gives one pulse.
   - Stream 1,0,1,0 gives none.
   - `match_count` keeps its pre-load value.
5. Reset mid-match: bits 1,0,1, then `reset` for 1 cycle, then 0.
   - No pulse.
   - After that, 1,0,1,0 gives a pulse.
   - All outputs are 0 the cycle after reset.
6. Counter (`CNT_W`=2, macro defined): 5 overlapping matches.
   - Count saturates at 3.
   - `cnt_clr` concurrent with a 6th match gives 0.
   - With the macro undefined, `match_count` stays 0 throughout.
